// File: rtl/fx_narrow_sat.sv
// fx_narrow_sat: pipelined fixed-point narrowing converter.
// Converts a wide signed IW.IFR sample to a signed OW.OFR sample:
// fractional LSBs are dropped with truncation or round-half-up (RND),
// integer MSBs are removed with saturation or wrap (SAT).
// Pipeline: input register -> quantise register -> overflow/output register,
// so a sample accepted on edge N is presented after edge N+2.
// Optional build macro FX_NARROW_STATS_EN adds a saturating 16-bit
// overflow event counter on output o_ovf_cnt.
module fx_narrow_sat #(
  parameter int IW  = 16,
  parameter int IFR = 10,
  parameter int OW  = 12,
  parameter int OFR = 7,
  parameter int RND = 1,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [IW-1:0] i_data,
  input  logic          i_clr,
  output logic          o_valid,
  output logic [OW-1:0] o_data,
  output logic          o_ovf,
  output logic          o_ovf_sticky
`ifdef FX_NARROW_STATS_EN
  ,
  output logic [15:0]   o_ovf_cnt
`endif
);

  // Reject parameter sets that would lose integer range or need left shifts.
  if ((IFR < OFR) || ((IW - IFR) < (OW - OFR)) || (OW < 2)) begin : g_param_check
    $error("fx_narrow_sat: illegal parameter set");
  end

  localparam int SH   = IFR - OFR;
  localparam int SHM1 = (SH > 0) ? (SH - 1) : 0;

  // Half an output LSB expressed in input LSBs; zero when truncating or SH=0.
  localparam logic [IW:0] ONE_W   = {{IW{1'b0}}, 1'b1};
  localparam logic [IW:0] RND_ADD = ((RND != 0) && (SH > 0)) ? (ONE_W << SHM1) : {(IW+1){1'b0}};

  // Output range limits, sign-extended to the quantiser width.
  localparam logic signed [IW:0] MAX_V = {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW:0] MIN_V = {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  // Stage 0: registered input.
  logic          in_valid_q, in_valid_d;
  logic [IW-1:0] in_data_q,  in_data_d;

  // Stage 1: quantised value, kept one bit wider than the input so the
  // rounding carry of the largest positive input survives.
  logic                 q_valid_q, q_valid_d;
  logic signed [IW:0]   q_q,       q_d;
  logic signed [IW:0]   ext_s;
  logic signed [IW:0]   sum_s;

  // Stage 2: outputs and status.
  logic          o_valid_q, o_valid_d;
  logic [OW-1:0] o_data_q,  o_data_d;
  logic          o_ovf_q,   o_ovf_d;
  logic          sticky_q,  sticky_d;
  logic          gt_max_s,  lt_min_s;

  // Input register: capture a sample only when it is qualified.
  always_comb begin
    in_valid_d = i_valid;
    if (i_valid) begin
      in_data_d = i_data;
    end else begin
      in_data_d = in_data_q;
    end
  end

  // Quantiser: optional half-LSB add in IW+1 bits, then arithmetic shift.
  always_comb begin
    ext_s     = $signed({in_data_q[IW-1], in_data_q});
    sum_s     = ext_s + $signed(RND_ADD);
    q_valid_d = in_valid_q;
    if (in_valid_q) begin
      q_d = sum_s >>> SH;
    end else begin
      q_d = q_q;
    end
  end

  // Range check and saturate/wrap selection for the output stage.
  always_comb begin
    gt_max_s  = (q_q > MAX_V);
    lt_min_s  = (q_q < MIN_V);
    o_valid_d = q_valid_q;
    if (q_valid_q) begin
      o_ovf_d = gt_max_s | lt_min_s;
      if ((SAT != 0) && gt_max_s) begin
        o_data_d = MAX_V[OW-1:0];
      end else if ((SAT != 0) && lt_min_s) begin
        o_data_d = MIN_V[OW-1:0];
      end else begin
        o_data_d = q_q[OW-1:0];
      end
    end else begin
      o_ovf_d  = 1'b0;
      o_data_d = o_data_q;
    end
  end

  // Sticky overflow: a presented overflow wins over a coincident clear.
  always_comb begin
    if (o_valid_q && o_ovf_q) begin
      sticky_d = 1'b1;
    end else if (i_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Pipeline and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      in_data_q  <= {IW{1'b0}};
      q_valid_q  <= 1'b0;
      q_q        <= {(IW+1){1'b0}};
      o_valid_q  <= 1'b0;
      o_data_q   <= {OW{1'b0}};
      o_ovf_q    <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
      q_valid_q  <= q_valid_d;
      q_q        <= q_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_ovf_q    <= o_ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  assign o_valid      = o_valid_q;
  assign o_data       = o_data_q;
  assign o_ovf        = o_ovf_q;
  assign o_ovf_sticky = sticky_q;

`ifdef FX_NARROW_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic        cnt_inc_s;

  // Overflow event counter: saturates at all-ones; clear plus event gives 1.
  always_comb begin
    cnt_inc_s = o_valid_q & o_ovf_q;
    if (i_clr) begin
      cnt_d = cnt_inc_s ? 16'd1 : 16'd0;
    end else if (cnt_inc_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_ovf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fx_narrow_sat.sv
// Testbench for fx_narrow_sat: four instances cover every RND/SAT
// combination at the default widths; a scoreboard queue holds expected
// outputs produced by an integer reference model.
module tb_fx_narrow_sat;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [15:0] i_data;
  logic        i_clr;

  logic [3:0]  ov_a;
  logic [11:0] od_a [4];
  logic [3:0]  oo_a;
  logic [3:0]  os_a;
`ifdef FX_NARROW_STATS_EN
  logic [15:0] oc_a [4];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int              cyc;
    logic [3:0][11:0] d;
    logic [3:0]      ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance g: RND = 1 for even g, SAT = 1 for g < 2.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    fx_narrow_sat #(
      .IW(16), .IFR(10), .OW(12), .OFR(7),
      .RND(1 - (g % 2)), .SAT(1 - (g / 2))
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .i_clr        (i_clr),
      .o_valid      (ov_a[g]),
      .o_data       (od_a[g]),
      .o_ovf        (oo_a[g]),
`ifdef FX_NARROW_STATS_EN
      .o_ovf_cnt    (oc_a[g]),
`endif
      .o_ovf_sticky (os_a[g])
    );
  end

  function automatic int rnd_of(input int i);
    return ((i % 2) == 0) ? 1 : 0;
  endfunction

  function automatic int sat_of(input int i);
    return (i < 2) ? 1 : 0;
  endfunction

  // Reference: value/8 with floor division, optional +4 (half output LSB) first.
  function automatic logic [12:0] model(input logic [15:0] din, input int rnd, input int sat);
    int v, a, q, r;
    logic [31:0] t;
    logic ovf;
    v = int'($signed(din));
    a = (rnd != 0) ? v + 4 : v;
    if (a >= 0) q = a / 8;
    else        q = -((-a + 7) / 8);
    ovf = (q > 2047) || (q < -2048);
    if ((sat != 0) && (q > 2047))       r = 2047;
    else if ((sat != 0) && (q < -2048)) r = -2048;
    else                                r = q;
    t = r;
    return {ovf, t[11:0]};
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h (cycle %0d)", tag, idx, got, exp, cyc);
    end
  endtask

  task automatic send(input logic [15:0] d);
    exp_t e;
    logic [12:0] m;
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = d;
    e.cyc = cyc + 3;
    for (int i = 0; i < 4; i++) begin
      m = model(d, rnd_of(i), sat_of(i));
      e.d[i]   = m[11:0];
      e.ovf[i] = m[12];
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_data  = 16'($urandom);
      i_clr   = 1'b0;
    end
  endtask

  // Monitor and status model: checks every instance on every falling edge,
  // then advances the sticky/counter model for the coming rising edge.
  logic [3:0]  m_sticky = 4'b0;
  logic [11:0] last_d [4];
  logic [15:0] m_cnt [4];
  initial begin
    exp_t e;
    logic ev;
    for (int i = 0; i < 4; i++) begin
      last_d[i] = 12'h000;
      m_cnt[i]  = 16'h0000;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_sticky = 4'b0;
        for (int i = 0; i < 4; i++) begin
          last_d[i] = 12'h000;
          m_cnt[i]  = 16'h0000;
        end
      end
      ev = (sb.size() > 0) && (sb[0].cyc == cyc);
      if (ev) e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk("o_valid", i, 32'(ov_a[i]), 32'(ev));
        if (ev) begin
          chk("o_data", i, 32'(od_a[i]), 32'(e.d[i]));
          chk("o_ovf", i, 32'(oo_a[i]), 32'(e.ovf[i]));
          last_d[i] = e.d[i];
        end else begin
          chk("o_data_hold", i, 32'(od_a[i]), 32'(last_d[i]));
          chk("o_ovf_idle", i, 32'(oo_a[i]), 32'd0);
        end
        chk("o_ovf_sticky", i, 32'(os_a[i]), 32'(m_sticky[i]));
`ifdef FX_NARROW_STATS_EN
        chk("o_ovf_cnt", i, 32'(oc_a[i]), 32'(m_cnt[i]));
`endif
        if (rst_n) begin
          if (ev && e.ovf[i]) begin
            m_sticky[i] = 1'b1;
          end else if (i_clr) begin
            m_sticky[i] = 1'b0;
          end
          if (i_clr) begin
            m_cnt[i] = (ev && e.ovf[i]) ? 16'd1 : 16'd0;
          end else if (ev && e.ovf[i] && (m_cnt[i] != 16'hFFFF)) begin
            m_cnt[i] = m_cnt[i] + 16'd1;
          end
        end
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    logic [15:0] dir_vec [8];
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 16'h0000;
    i_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Rounding ties, boundaries, saturation and wrap.
    dir_vec[0] = 16'h0004; dir_vec[1] = 16'hFFFC; dir_vec[2] = 16'hFFF4; dir_vec[3] = 16'h3FF8;
    dir_vec[4] = 16'h3FFC; dir_vec[5] = 16'h4000; dir_vec[6] = 16'h8000; dir_vec[7] = 16'h7FFF;
    for (int k = 0; k < 8; k++) send(dir_vec[k]);
    idle(5);
    chk("sticky_after_ovf", 0, 32'(os_a[0]), 32'd1);

    // Clear, then sticky rises on first overflow and holds.
    @(posedge clk); #1 i_clr = 1'b1;
    idle(2);
    chk("sticky_cleared", 0, 32'(os_a[0]), 32'd0);
    send(16'h0100);
    idle(4);
    chk("sticky_no_ovf", 0, 32'(os_a[0]), 32'd0);
    send(16'h4000);
    send(16'h0008);
    send(16'h0010);
    idle(5);
    chk("sticky_held", 0, 32'(os_a[0]), 32'd1);

    // Clear alone, then clear coincident with a presented overflow.
    @(posedge clk); #1 i_clr = 1'b1;
    idle(3);
    send(16'h4000);
    idle(2);
    @(posedge clk); #1 i_clr = 1'b1;
    idle(2);
    chk("sticky_clr_coincident", 0, 32'(os_a[0]), 32'd1);

    // Back-to-back random stream.
    for (int k = 0; k < 100; k++) begin
      if ((k % 7) == 3) send(16'h8000 + 16'(k));
      else              send(16'($urandom));
    end
    idle(5);

    // Mid-stream reset with two samples in flight.
    @(posedge clk); #1 i_clr = 1'b1;
    idle(1);
    send(16'h4000);
    send(16'h8000);
    @(posedge clk); #1;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("valid_in_reset", 0, 32'(ov_a[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    send(16'h4000);
    send(16'h8000);
    send(16'h7FFF);
    idle(6);
    chk("sticky_post_reset", 0, 32'(os_a[0]), 32'd1);
`ifdef FX_NARROW_STATS_EN
    chk("cnt_post_reset", 0, 32'(oc_a[0]), 32'd3);
`endif
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
